// File: rtl/norm_ctrl_pkg.sv
// Shared definitions for the normalization sequencer: state encoding and
// default datapath sizing.
package norm_ctrl_pkg;

  localparam int DWIDTH_DEF       = 8;
  localparam int MAT_MUL_SIZE_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COLLECT = 3'd2,
    STREAM  = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/norm_row_fifo.sv
// Small synchronous row FIFO holding one tile of matmul rows; the head row is
// presented combinationally so the sequencer can register it on the pop cycle.
module norm_row_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int              PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [PW:0]     DEPTH_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap explicitly so non-power-of-two depths stay correct.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/norm_ctrl.sv
// Feeds the norm block one full tile at a time: buffers MAT_MUL_SIZE rows,
// replays them as a gap-free burst, and reports completion from norm's outputs.
module norm_ctrl
  import norm_ctrl_pkg::*;
#(
  parameter int DWIDTH       = DWIDTH_DEF,
  parameter int MAT_MUL_SIZE = MAT_MUL_SIZE_DEF,
  parameter int NUM_SETS     = 4,
  parameter int SEL_W        = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [SEL_W-1:0]               param_sel,
  input  logic                           cfg_we,
  input  logic [SEL_W-1:0]               cfg_addr,
  input  logic [DWIDTH-1:0]              cfg_mean,
  input  logic [DWIDTH-1:0]              cfg_inv_var,
  input  logic                           src_valid,
  output logic                           src_ready,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] src_data,
  output logic                           norm_in_data_available,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] norm_inp_data,
  output logic [DWIDTH-1:0]              norm_mean,
  output logic [DWIDTH-1:0]              norm_inv_var,
  input  logic                           norm_out_data_available,
  output logic                           busy,
  output logic                           done
);

  localparam int             CW       = $clog2(MAT_MUL_SIZE) + 1;
  localparam int             RW       = MAT_MUL_SIZE * DWIDTH;
  localparam logic [CW-1:0]  LAST_CNT = CW'(MAT_MUL_SIZE - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(MAT_MUL_SIZE);

  state_t            state;
  logic [SEL_W-1:0]  sel_reg;
  logic [DWIDTH-1:0] mean_tbl [NUM_SETS];
  logic [DWIDTH-1:0] inv_tbl  [NUM_SETS];
  logic [CW-1:0]     in_cnt;
  logic [CW-1:0]     stream_cnt;
  logic [CW-1:0]     out_cnt;
  logic [CW-1:0]     out_cnt_next;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              last_accept;
  logic              counting;
  logic [RW-1:0]     fifo_data;

  assign fifo_push   = src_valid && src_ready && !fifo_full;
  assign last_accept = (state == COLLECT) && fifo_push && (in_cnt == LAST_CNT);
  // The first pop rides on the last accept so the burst starts the very next cycle.
  assign fifo_pop    = !fifo_empty &&
                       (last_accept || ((state == STREAM) && (stream_cnt != LAST_CNT)));

  assign counting     = (state == STREAM) || (state == DRAIN);
  assign out_cnt_next = (counting && norm_out_data_available && (out_cnt != FULL_CNT))
                        ? out_cnt + 1'b1 : out_cnt;

  norm_row_fifo #(
    .WIDTH (RW),
    .DEPTH (MAT_MUL_SIZE)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (src_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        mean_tbl[i] <= '0;
        inv_tbl[i]  <= '0;
      end
    end else if (cfg_we) begin
      mean_tbl[cfg_addr] <= cfg_mean;
      inv_tbl[cfg_addr]  <= cfg_inv_var;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      sel_reg                <= '0;
      src_ready              <= 1'b0;
      norm_in_data_available <= 1'b0;
      norm_inp_data          <= '0;
      norm_mean              <= '0;
      norm_inv_var           <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      in_cnt                 <= '0;
      stream_cnt             <= '0;
      out_cnt                <= '0;
    end else begin
      done    <= 1'b0;
      out_cnt <= out_cnt_next;
      case (state)
        IDLE: begin
          if (start) begin
            sel_reg <= param_sel;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          // Same-cycle cfg writes land after this read, so the tile keeps the old entry.
          norm_mean    <= mean_tbl[sel_reg];
          norm_inv_var <= inv_tbl[sel_reg];
          in_cnt       <= '0;
          stream_cnt   <= '0;
          out_cnt      <= '0;
          src_ready    <= 1'b1;
          state        <= COLLECT;
        end
        COLLECT: begin
          if (fifo_push) begin
            if (in_cnt != FULL_CNT) begin
              in_cnt <= in_cnt + 1'b1;
            end
            if (last_accept) begin
              src_ready              <= 1'b0;
              norm_in_data_available <= 1'b1;
              norm_inp_data          <= fifo_data;
              state                  <= STREAM;
            end
          end
        end
        STREAM: begin
          if (stream_cnt != LAST_CNT) begin
            stream_cnt    <= stream_cnt + 1'b1;
            norm_inp_data <= fifo_data;
          end else begin
            norm_in_data_available <= 1'b0;
            // In bypass all outputs may already be counted, skipping DRAIN.
            if (out_cnt_next == FULL_CNT) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_cnt_next == FULL_CNT) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_ctrl.sv
// Directed bench for norm_ctrl with a stand-in norm block and a tile-level
// model of the expected burst, norm outputs and completion timing.
module tb_norm_ctrl;

  localparam int N  = 4;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    param_sel = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [7:0]    cfg_mean = '0;
  logic [7:0]    cfg_inv_var = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [RW-1:0] src_data = '0;
  logic          norm_in_data_available;
  logic [RW-1:0] norm_inp_data;
  logic [7:0]    norm_mean;
  logic [7:0]    norm_inv_var;
  logic          norm_out_data_available;
  logic          busy;
  logic          done;

  logic          enable_norm = 1'b1;
  logic          nq_valid;
  logic [RW-1:0] nq_data;
  logic [RW-1:0] norm_out_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Tile-level model state
  logic [7:0]    tbl_m [4];
  logic [7:0]    tbl_v [4];
  logic [7:0]    exp_mean;
  logic [7:0]    exp_inv;
  logic [RW-1:0] exp_rows [$];
  logic [RW-1:0] exp_out [$];
  logic [RW-1:0] last_out = '0;
  int            run = 0;
  int            rows_seen = 0;
  int            done_count = 0;
  int            done_cyc = 0;
  bit            prev_avail = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  norm_ctrl dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .param_sel               (param_sel),
    .cfg_we                  (cfg_we),
    .cfg_addr                (cfg_addr),
    .cfg_mean                (cfg_mean),
    .cfg_inv_var             (cfg_inv_var),
    .src_valid               (src_valid),
    .src_ready               (src_ready),
    .src_data                (src_data),
    .norm_in_data_available  (norm_in_data_available),
    .norm_inp_data           (norm_inp_data),
    .norm_mean               (norm_mean),
    .norm_inv_var            (norm_inv_var),
    .norm_out_data_available (norm_out_data_available),
    .busy                    (busy),
    .done                    (done)
  );

  // Per lane: (x - mean) * inv_var, kept to 8 bits.
  function automatic logic [RW-1:0] norm_fn(input logic [RW-1:0] x, input logic [7:0] m,
                                            input logic [7:0] v);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*8 +: 8] = 8'((x[i*8 +: 8] - m) * v);
    end
    return r;
  endfunction

  // Stand-in norm block: one-cycle latency when enabled, pass-through in bypass.
  always @(posedge clk) begin
    if (reset) begin
      nq_valid <= 1'b0;
      nq_data  <= '0;
    end else begin
      nq_valid <= norm_in_data_available;
      nq_data  <= norm_fn(norm_inp_data, norm_mean, norm_inv_var);
    end
  end
  assign norm_out_data_available = enable_norm ? nq_valid : norm_in_data_available;
  assign norm_out_data           = enable_norm ? nq_data : norm_inp_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: checks burst contents, burst shape and norm outputs each cycle.
  always @(negedge clk) begin
    logic [RW-1:0] r;
    if (reset) begin
      exp_rows.delete();
      exp_out.delete();
      prev_avail = 1'b0;
      run = 0;
    end else begin
      if (norm_in_data_available) begin
        chk("src_ready_low_in_stream", {31'd0, src_ready}, 32'd0);
        chk("busy_in_stream", {31'd0, busy}, 32'd1);
        chk("norm_mean", {24'd0, norm_mean}, {24'd0, exp_mean});
        chk("norm_inv_var", {24'd0, norm_inv_var}, {24'd0, exp_inv});
        if (exp_rows.size() == 0) begin
          chk("rows_pending", 32'(exp_rows.size()), 32'd1);
        end else begin
          r = exp_rows.pop_front();
          chk("norm_inp_data", norm_inp_data, r);
          exp_out.push_back(enable_norm ? norm_fn(r, exp_mean, exp_inv) : r);
        end
        run++;
        rows_seen++;
      end else if (prev_avail) begin
        chk("burst_length", 32'(run), 32'(N));
        run = 0;
      end
      prev_avail = norm_in_data_available;
      if (norm_out_data_available) begin
        if (exp_out.size() == 0) begin
          chk("outputs_pending", 32'(exp_out.size()), 32'd1);
        end else begin
          r = exp_out.pop_front();
          chk("norm_out_data", norm_out_data, r);
        end
        last_out = norm_out_data;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        chk("busy_at_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_src_ready"}, {31'd0, src_ready}, 32'd0);
    chk({tag, "_in_avail"}, {31'd0, norm_in_data_available}, 32'd0);
    chk({tag, "_inp_data"}, norm_inp_data, 32'd0);
    chk({tag, "_mean"}, {24'd0, norm_mean}, 32'd0);
    chk({tag, "_inv_var"}, {24'd0, norm_inv_var}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic write_cfg(input logic [1:0] a, input logic [7:0] m, input logic [7:0] v);
    cfg_we = 1'b1; cfg_addr = a; cfg_mean = m; cfg_inv_var = v;
    tick();
    cfg_we = 1'b0;
    tbl_m[a] = m;
    tbl_v[a] = v;
  endtask

  // lanes holds one lane value per row (row k = byte k replicated across lanes).
  task automatic run_tile(input logic [1:0] sel, input logic [31:0] lanes, input bit toggle,
                          input bit collide, input bit restart, input int exp_lat);
    int i, g, start_cyc, last_acc;
    bit ph;
    exp_mean = tbl_m[sel];
    exp_inv  = tbl_v[sel];
    for (int k = 0; k < N; k++) exp_rows.push_back({4{lanes[k*8 +: 8]}});
    done_count = 0;
    start = 1'b1; param_sel = sel;
    @(negedge clk);
    start_cyc = cyc;
    tick();
    start = 1'b0;
    if (collide) begin
      cfg_we = 1'b1; cfg_addr = sel; cfg_mean = 8'd7; cfg_inv_var = tbl_v[sel];
    end
    tick();
    cfg_we = 1'b0;
    if (collide) tbl_m[sel] = 8'd7;
    i = 0; g = 0; ph = 1'b1; last_acc = 0;
    while (i < N && g < 100) begin
      src_valid = toggle ? ph : 1'b1;
      src_data  = {4{lanes[i*8 +: 8]}};
      if (restart && g == 1) begin
        start = 1'b1; param_sel = 2'd2;
      end
      @(negedge clk);
      if (src_valid && src_ready) begin
        i++;
        last_acc = cyc;
      end
      tick();
      start = 1'b0;
      ph = !ph;
      g++;
    end
    src_valid = 1'b0;
    chk("rows_accepted", 32'(i), 32'(N));
    g = 0;
    while (done_count == 0 && g < 40) begin
      tick();
      g++;
    end
    chk("done_seen", 32'(done_count), 32'd1);
    if (done_count > 0) begin
      chk("last_row_to_done", 32'(done_cyc - last_acc), enable_norm ? 32'd6 : 32'd5);
      if (exp_lat > 0) chk("start_to_done", 32'(done_cyc - start_cyc), 32'(exp_lat));
    end
    repeat (4) tick();
    chk("done_once", 32'(done_count), 32'd1);
    chk("busy_after_tile", {31'd0, busy}, 32'd0);
    chk("rows_left", 32'(exp_rows.size()), 32'd0);
    chk("outputs_left", 32'(exp_out.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    for (int k = 0; k < 4; k++) begin
      tbl_m[k] = '0;
      tbl_v[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // Basic tile: (5-2)*3 = 9 on every lane, 11 cycles start to done.
    write_cfg(2'd1, 8'd2, 8'd3);
    run_tile(2'd1, 32'h05050505, 1'b0, 1'b0, 1'b0, 11);
    chk("t1_mean_held", {24'd0, norm_mean}, 32'd2);
    chk("t1_inv_held", {24'd0, norm_inv_var}, 32'd3);
    chk("t1_last_out", last_out, 32'h09090909);

    // Upstream bubbles
    run_tile(2'd1, 32'h04030201, 1'b1, 1'b0, 1'b0, -1);

    // Bypass: raw rows come back, one cycle earlier.
    enable_norm = 1'b0;
    run_tile(2'd1, 32'h04030201, 1'b0, 1'b0, 1'b0, 10);
    chk("t3_last_out", last_out, 32'h04040404);
    enable_norm = 1'b1;

    // Config write to entry 1 during its LOAD cycle.
    run_tile(2'd1, 32'h06060606, 1'b0, 1'b1, 1'b0, 11);
    chk("t4_mean_old", {24'd0, norm_mean}, 32'd2);
    chk("t4_last_out", last_out, 32'h0c0c0c0c);
    run_tile(2'd1, 32'h09090909, 1'b0, 1'b0, 1'b0, 11);
    chk("t4b_mean_new", {24'd0, norm_mean}, 32'd7);
    chk("t4b_last_out", last_out, 32'h06060606);

    // Start pulse during COLLECT is ignored.
    run_tile(2'd1, 32'h08080808, 1'b0, 1'b0, 1'b1, 11);
    chk("t6_mean_kept", {24'd0, norm_mean}, 32'd7);
    chk("t6_last_out", last_out, 32'h03030303);

    // Reset after two rows of the burst.
    exp_mean = tbl_m[1];
    exp_inv  = tbl_v[1];
    for (int k = 0; k < N; k++) exp_rows.push_back(32'h03030303);
    rows_seen = 0;
    done_count = 0;
    start = 1'b1; param_sel = 2'd1;
    tick();
    start = 1'b0;
    tick();
    src_valid = 1'b1; src_data = 32'h03030303;
    repeat (N) tick();
    src_valid = 1'b0;
    g = 0;
    while (rows_seen < 2 && g < 20) begin
      tick();
      g++;
    end
    chk("t5_rows_before_reset", 32'(rows_seen), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("t5_after_reset");
    for (int k = 0; k < 4; k++) begin
      tbl_m[k] = '0;
      tbl_v[k] = '0;
    end
    repeat (20) tick();
    chk("t5_no_done", 32'(done_count), 32'd0);
    run_tile(2'd1, 32'h05050505, 1'b0, 1'b0, 1'b0, 11);
    chk("t5_mean_cleared", {24'd0, norm_mean}, 32'd0);
    chk("t5_last_out", last_out, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
